// File: rtl/hex_display_scheduler.sv
// Round-robin Avalon-MM master that shares the HEX3..HEX0 PIO register between two requesters.
// Optional leading-zero blanking is enabled by defining HEX_BLANK_EN.
module hex_display_scheduler #(
    parameter int unsigned PIO_ADDR   = 0,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] value0,
    input  logic [15:0] value1,
    output logic [1:0]  ack,
    output logic        busy,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest
);

    typedef enum logic [1:0] {IDLE, ENCODE, WRITE, ACK} state_t;

    localparam logic [1:0] ADDR     = PIO_ADDR[1:0];
    localparam logic [7:0] OFF_BYTE = ACTIVE_LOW ? 8'hFF : 8'h00;

    state_t      state;
    state_t      next_state;
    logic        last_grant;
    logic        grant;
    logic        next_grant;
    logic [15:0] held_value;
    logic [31:0] encoded;
    logic [3:0]  blank;

    // Segment bit 0 is segment a, bit 6 is segment g, active-high.
    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'h0: seg_code = 7'h3F;
            4'h1: seg_code = 7'h06;
            4'h2: seg_code = 7'h5B;
            4'h3: seg_code = 7'h4F;
            4'h4: seg_code = 7'h66;
            4'h5: seg_code = 7'h6D;
            4'h6: seg_code = 7'h7D;
            4'h7: seg_code = 7'h07;
            4'h8: seg_code = 7'h7F;
            4'h9: seg_code = 7'h6F;
            4'hA: seg_code = 7'h77;
            4'hB: seg_code = 7'h7C;
            4'hC: seg_code = 7'h39;
            4'hD: seg_code = 7'h5E;
            4'hE: seg_code = 7'h79;
            default: seg_code = 7'h71;
        endcase
    endfunction

`ifdef HEX_BLANK_EN
    // A digit is blank when it and every more-significant digit are zero; HEX0 always shows.
    assign blank = {~|held_value[15:12], ~|held_value[15:8], ~|held_value[15:4], 1'b0};
`else
    assign blank = 4'b0000;
`endif

    always_comb begin
        encoded = '0;
        for (int i = 0; i < 4; i++) begin
            if (blank[i])
                encoded[8*i +: 8] = OFF_BYTE;
            else if (ACTIVE_LOW)
                encoded[8*i +: 8] = {1'b1, ~seg_code(held_value[4*i +: 4])};
            else
                encoded[8*i +: 8] = {1'b0, seg_code(held_value[4*i +: 4])};
        end
    end

    // On a tie the requester that did not win last time is served.
    assign next_grant = (req == 2'b11) ? ~last_grant : req[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            grant         <= 1'b0;
            held_value    <= '0;
            avm_writedata <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && req != 2'b00) begin
                grant      <= next_grant;
                last_grant <= next_grant;
                held_value <= next_grant ? value1 : value0;
            end
            if (state == ENCODE)
                avm_writedata <= encoded;
        end
    end

    always_comb begin
        next_state     = state;
        busy           = 1'b1;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        ack            = 2'b00;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req != 2'b00)
                    next_state = ENCODE;
            end
            ENCODE: next_state = WRITE;
            WRITE: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                if (!avm_waitrequest)
                    next_state = ACK;
            end
            default: begin
                ack        = grant ? 2'b10 : 2'b01;
                next_state = IDLE;
            end
        endcase
    end

    assign avm_address = ADDR;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Self-checking bench for hex_display_scheduler: one active-low and one active-high instance
// share all inputs and are compared against a transaction-level reference model.
module tb_hex_display_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] value0;
    logic [15:0] value1;
    logic        waitreq;

    logic [1:0]  ack_l, ack_h, addr_l, addr_h;
    logic        busy_l, busy_h, cs_l, cs_h, wn_l, wn_h;
    logic [31:0] wd_l, wd_h;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [7:0] SEG_TABLE [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

`ifdef HEX_BLANK_EN
    localparam bit BLANKING = 1'b1;
`else
    localparam bit BLANKING = 1'b0;
`endif

    hex_display_scheduler #(.PIO_ADDR(0), .ACTIVE_LOW(1'b1)) u_dut_al (
        .clk(clk), .reset(reset), .req(req), .value0(value0), .value1(value1),
        .ack(ack_l), .busy(busy_l), .avm_address(addr_l), .avm_chipselect(cs_l),
        .avm_write_n(wn_l), .avm_writedata(wd_l), .avm_waitrequest(waitreq)
    );

    hex_display_scheduler #(.PIO_ADDR(0), .ACTIVE_LOW(1'b0)) u_dut_ah (
        .clk(clk), .reset(reset), .req(req), .value0(value0), .value1(value1),
        .ack(ack_h), .busy(busy_h), .avm_address(addr_h), .avm_chipselect(cs_h),
        .avm_write_n(wn_h), .avm_writedata(wd_h), .avm_waitrequest(waitreq)
    );

    always #5 clk = ~clk;

    // Display word built digit by digit from the code table.
    function automatic logic [31:0] model_word(input logic [15:0] v, input bit active_low);
        logic [31:0] word;
        logic [7:0]  b;
        int          upper;
        word = '0;
        for (int i = 0; i < 4; i++) begin
            upper = int'(v) >> (4 * i);
            b = SEG_TABLE[upper % 16];
            if (BLANKING && i > 0 && upper == 0)
                b = 8'h00;
            if (active_low)
                b = b ^ 8'hFF;
            word = word | (32'(b) << (8 * i));
        end
        return word;
    endfunction

    // Transaction timeline: 0 idle, 1 grant taken, 2 bus write pending, 3 completion.
    int          m_phase;
    int          m_last;
    int          m_grant;
    logic [15:0] m_value;
    logic [31:0] m_wd_l, m_wd_h;

    task automatic model_reset();
        m_phase = 0;
        m_last  = 1;
        m_grant = 0;
        m_value = '0;
        m_wd_l  = '0;
        m_wd_h  = '0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (req != 2'b00) begin
                    if (req == 2'b11) m_grant = 1 - m_last;
                    else              m_grant = req[1] ? 1 : 0;
                    m_last  = m_grant;
                    m_value = (m_grant == 1) ? value1 : value0;
                    m_phase = 1;
                end
                1: begin
                    m_wd_l  = model_word(m_value, 1'b1);
                    m_wd_h  = model_word(m_value, 1'b0);
                    m_phase = 2;
                end
                2: if (!waitreq) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
    endtask

    function automatic logic [1:0] model_ack();
        if (m_phase != 3) return 2'b00;
        return (m_grant == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check("busy_al", 32'(busy_l), 32'(m_phase != 0));
        check("busy_ah", 32'(busy_h), 32'(m_phase != 0));
        check("cs_al",   32'(cs_l),   32'(m_phase == 2));
        check("cs_ah",   32'(cs_h),   32'(m_phase == 2));
        check("wn_al",   32'(wn_l),   32'(m_phase != 2));
        check("wn_ah",   32'(wn_h),   32'(m_phase != 2));
        check("ack_al",  32'(ack_l),  32'(model_ack()));
        check("ack_ah",  32'(ack_h),  32'(model_ack()));
        check("wd_al",   wd_l,        m_wd_l);
        check("wd_ah",   wd_h,        m_wd_h);
        check("addr_al", 32'(addr_l), 32'd0);
        check("addr_ah", 32'(addr_h), 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        checkOutput();
    endtask

    typedef struct packed {
        logic [1:0]  req;
        logic [15:0] v0;
        logic [15:0] v1;
        logic [31:0] exp_al;
        logic [31:0] exp_ah;
        logic [1:0]  exp_ack;
    } vec_t;

    // One uncontested transaction with fixed latency and constant expectations.
    task automatic applyStimulus(input vec_t v);
        req     = v.req;
        value0  = v.v0;
        value1  = v.v1;
        waitreq = 1'b0;
        cycle();
        cycle();
        check("tbl_cs", 32'(cs_l), 32'd1);
        check("tbl_wn", 32'(wn_h), 32'd0);
        check("tbl_wd_al", wd_l, v.exp_al);
        check("tbl_wd_ah", wd_h, v.exp_ah);
        cycle();
        check("tbl_ack", 32'(ack_l), 32'(v.exp_ack));
        req = 2'b00;
        cycle();
        check("tbl_busy_after", 32'(busy_l), 32'd0);
    endtask

    vec_t vecs [6];
    int   grants [$];
    logic [31:0] held_word;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef HEX_BLANK_EN
        vecs[0] = '{2'b01, 16'h1234, 16'h0000, 32'hF9A4B099, 32'h065B4F66, 2'b01};
        vecs[1] = '{2'b10, 16'h0000, 16'h00AF, 32'hFFFF888E, 32'h00007771, 2'b10};
        vecs[2] = '{2'b01, 16'h0000, 16'hFFFF, 32'hFFFFFFC0, 32'h0000003F, 2'b01};
        vecs[3] = '{2'b10, 16'h0000, 16'hFEDC, 32'h8E86A1C6, 32'h71795E39, 2'b10};
        vecs[4] = '{2'b01, 16'h8765, 16'h0000, 32'h80F88292, 32'h7F077D6D, 2'b01};
        vecs[5] = '{2'b01, 16'h0090, 16'h1111, 32'hFFFF90C0, 32'h00006F3F, 2'b01};
`else
        vecs[0] = '{2'b01, 16'h1234, 16'h0000, 32'hF9A4B099, 32'h065B4F66, 2'b01};
        vecs[1] = '{2'b10, 16'h0000, 16'h00AF, 32'hC0C0888E, 32'h3F3F7771, 2'b10};
        vecs[2] = '{2'b01, 16'h0000, 16'hFFFF, 32'hC0C0C0C0, 32'h3F3F3F3F, 2'b01};
        vecs[3] = '{2'b10, 16'h0000, 16'hFEDC, 32'h8E86A1C6, 32'h71795E39, 2'b10};
        vecs[4] = '{2'b01, 16'h8765, 16'h0000, 32'h80F88292, 32'h7F077D6D, 2'b01};
        vecs[5] = '{2'b01, 16'h0090, 16'h1111, 32'hC0C090C0, 32'h3F3F6F3F, 2'b01};
`endif
        reset   = 1'b1;
        req     = 2'b00;
        value0  = '0;
        value1  = '0;
        waitreq = 1'b0;
        model_reset();
        #1;
        check("rst_busy", 32'(busy_l), 32'd0);
        check("rst_cs",   32'(cs_h),   32'd0);
        check("rst_wn",   32'(wn_l),   32'd1);
        check("rst_ack",  32'(ack_l),  32'd0);
        check("rst_wd",   wd_l,        32'd0);
        check("rst_addr", 32'(addr_h), 32'd0);
        cycle();
        cycle();
        reset = 1'b0;

        $display("[TB] round-robin with both requesters held");
        req    = 2'b11;
        value0 = 16'hA000;
        value1 = 16'h000B;
        for (int c = 0; c < 16; c++) begin
            cycle();
            if (ack_l == 2'b01) grants.push_back(0);
            if (ack_l == 2'b10) grants.push_back(1);
        end
        req = 2'b00;
        check("rr_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size(); i++)
            check("rr_order", 32'(grants[i]), 32'(i % 2));
        cycle();

        $display("[TB] table-driven single transactions");
        for (int i = 0; i < 6; i++)
            applyStimulus(vecs[i]);

        $display("[TB] waitrequest stall");
        held_word = model_word(16'hBEEF, 1'b1);
        value0  = 16'hBEEF;
        req     = 2'b01;
        waitreq = 1'b1;
        cycle();
        cycle();
        for (int k = 0; k < 5; k++) begin
            check("stall_cs", 32'(cs_l), 32'd1);
            check("stall_wn", 32'(wn_l), 32'd0);
            check("stall_wd", wd_l, held_word);
            check("stall_ack", 32'(ack_l), 32'd0);
            cycle();
        end
        waitreq = 1'b0;
        cycle();
        check("stall_ack_after", 32'(ack_l), 32'd1);
        check("stall_cs_after", 32'(cs_l), 32'd0);
        req = 2'b00;
        cycle();

        $display("[TB] request dropped before completion");
        value0 = 16'h0042;
        req    = 2'b01;
        cycle();
        req = 2'b00;
        cycle();
        check("drop_cs", 32'(cs_h), 32'd1);
        check("drop_wd", wd_h, model_word(16'h0042, 1'b0));
        cycle();
        check("drop_ack", 32'(ack_h), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("drop_no_write", 32'(cs_l), 32'd0);
        end

        $display("[TB] reset in the middle of a write");
        value0  = 16'h5555;
        req     = 2'b01;
        waitreq = 1'b1;
        cycle();
        cycle();
        check("mid_cs_before", 32'(cs_l), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("mid_cs",   32'(cs_l),   32'd0);
        check("mid_wn",   32'(wn_h),   32'd1);
        check("mid_ack",  32'(ack_l),  32'd0);
        check("mid_wd",   wd_l,        32'd0);
        check("mid_busy", 32'(busy_h), 32'd0);
        model_reset();
        req     = 2'b10;
        value1  = 16'h0A0A;
        waitreq = 1'b0;
        cycle();
        reset = 1'b0;
        cycle();
        cycle();
        check("mid_wd_after", wd_h, model_word(16'h0A0A, 1'b0));
        cycle();
        check("mid_grant1", 32'(ack_l), 32'd2);
        req = 2'b00;
        cycle();

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (model_ack()[r] && $urandom_range(0, 9) < 7)
                    req[r] = 1'b0;
                else if (!req[r] && $urandom_range(0, 9) < 3)
                    req[r] = 1'b1;
                else if (req[r] && $urandom_range(0, 99) < 3)
                    req[r] = 1'b0;
            end
            value0  = 16'($urandom);
            value1  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            waitreq = ($urandom_range(0, 9) < 3);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
